// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: the substate codes seen by the PIPE control stage
// and the internal state encoding of the Detect front end.
package ltssm_pkg;

  localparam logic [4:0] SUB_DETECT_QUIET        = 5'd0;
  localparam logic [4:0] SUB_DETECT_ACTIVE       = 5'd1;
  localparam logic [4:0] SUB_POLLING_ACTIVE      = 5'd2;
  localparam logic [4:0] SUB_POLLING_COMPLIANCE  = 5'd3;
  localparam logic [4:0] SUB_POLLING_CONFIG      = 5'd4;
  localparam logic [4:0] SUB_CFG_LINKWIDTH_START = 5'd5;
  localparam logic [4:0] SUB_CFG_LINKWIDTH_ACC   = 5'd6;
  localparam logic [4:0] SUB_CFG_LANENUM_WAIT    = 5'd7;
  localparam logic [4:0] SUB_CFG_LANENUM_ACC     = 5'd8;
  localparam logic [4:0] SUB_CFG_COMPLETE        = 5'd9;
  localparam logic [4:0] SUB_CFG_IDLE            = 5'd10;
  localparam logic [4:0] SUB_L0                  = 5'd11;
  localparam logic [4:0] SUB_IDLE                = 5'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUIET,
    S_REQ,
    S_WAIT,
    S_POLL
  } state_t;

  function automatic logic [4:0] substate_of(input state_t s);
    case (s)
      S_QUIET:        return SUB_DETECT_QUIET;
      S_REQ, S_WAIT:  return SUB_DETECT_ACTIVE;
      S_POLL:         return SUB_POLLING_ACTIVE;
      default:        return SUB_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ltssm_timer.sv
// Loadable down-counter shared by the LTSSM state blocks; load beats
// decrement and the count parks at zero.
module ltssm_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ltssm_detect_ctrl.sv
// Detect front end of the LTSSM: Detect.Quiet -> Detect.Active -> Polling.Active
// with quiet/detect timeouts; all outputs registered from the next state.
module ltssm_detect_ctrl
  import ltssm_pkg::*;
#(
  parameter int number_of_lanes = 4,
  parameter int QUIET_CYCLES    = 300000,
  parameter int DETECT_TIMEOUT  = 1024,
  parameter int CNT_W           = 20
) (
  input  logic                       pclk,
  input  logic                       reset_n,
  input  logic                       link_enable,
  input  logic [number_of_lanes-1:0] RxElecIdle,
  input  logic                       Detect_status,
  output logic [4:0]                 substate,
  output logic                       ElecIdle_req,
  output logic                       Detect_req,
  output logic                       detect_done,
  output logic [7:0]                 detect_fail_cnt
);

  localparam logic [CNT_W-1:0] QUIET_LOAD  = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] DETECT_LOAD = CNT_W'(DETECT_TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic             quiet_first;
  logic             rx_active;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_zero;
  logic             fail_inc;

  assign rx_active = ~&RxElecIdle;

  ltssm_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (pclk),
    .rst_n    (reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_next   = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;
    fail_inc     = 1'b0;
    if (!link_enable) begin
      // Dropping the link clears the timer by loading zero.
      state_next = S_IDLE;
      tmr_load   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          state_next   = S_QUIET;
          tmr_load     = 1'b1;
          tmr_load_val = QUIET_LOAD;
        end
        S_QUIET: begin
          tmr_en = 1'b1;
          if (tmr_zero || (rx_active && !quiet_first)) state_next = S_REQ;
        end
        S_REQ: begin
          state_next   = S_WAIT;
          tmr_load     = 1'b1;
          tmr_load_val = DETECT_LOAD;
        end
        S_WAIT: begin
          tmr_en = 1'b1;
          if (Detect_status) begin
            state_next = S_POLL;
          end else if (tmr_zero) begin
            state_next   = S_QUIET;
            tmr_load     = 1'b1;
            tmr_load_val = QUIET_LOAD;
            fail_inc     = 1'b1;
          end
        end
        S_POLL:  state_next = S_POLL;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      quiet_first     <= 1'b0;
      substate        <= SUB_IDLE;
      ElecIdle_req    <= 1'b1;
      Detect_req      <= 1'b0;
      detect_done     <= 1'b0;
      detect_fail_cnt <= 8'd0;
    end else begin
      state        <= state_next;
      quiet_first  <= (state_next == S_QUIET) && (state != S_QUIET);
      substate     <= substate_of(state_next);
      ElecIdle_req <= (state_next != S_POLL);
      Detect_req   <= (state_next == S_REQ);
      detect_done  <= (state_next == S_POLL) && (state != S_POLL);
      if (fail_inc && (detect_fail_cnt != 8'hFF)) begin
        detect_fail_cnt <= detect_fail_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ltssm_detect_ctrl.sv
// Directed bench for ltssm_detect_ctrl: phase/age reference model compared
// every cycle, plus literal expectations at the key points of each scenario.
module tb_ltssm_detect_ctrl;

  localparam int LANES = 4;
  localparam int QC    = 16;
  localparam int DT    = 8;
  localparam int CW    = 20;

  localparam int P_IDLE  = 0;
  localparam int P_QUIET = 1;
  localparam int P_REQ   = 2;
  localparam int P_WAIT  = 3;
  localparam int P_POLL  = 4;

  logic             pclk          = 1'b0;
  logic             reset_n       = 1'b0;
  logic             link_enable   = 1'b0;
  logic [LANES-1:0] RxElecIdle    = '1;
  logic             Detect_status = 1'b0;
  logic [4:0]       substate;
  logic             ElecIdle_req;
  logic             Detect_req;
  logic             detect_done;
  logic [7:0]       detect_fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  always #5 pclk = ~pclk;

  ltssm_detect_ctrl #(
    .number_of_lanes (LANES),
    .QUIET_CYCLES    (QC),
    .DETECT_TIMEOUT  (DT),
    .CNT_W           (CW)
  ) dut (
    .pclk            (pclk),
    .reset_n         (reset_n),
    .link_enable     (link_enable),
    .RxElecIdle      (RxElecIdle),
    .Detect_status   (Detect_status),
    .substate        (substate),
    .ElecIdle_req    (ElecIdle_req),
    .Detect_req      (Detect_req),
    .detect_done     (detect_done),
    .detect_fail_cnt (detect_fail_cnt)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // Reference model: which phase the link is in and how many cycles it has been there.
  int m_phase = P_IDLE;
  int m_age   = 0;
  int m_fails = 0;
  int n_phase;
  int n_age;
  int n_fails;
  logic [4:0] e_sub  = 5'd15;
  logic       e_ei   = 1'b1;
  logic       e_req  = 1'b0;
  logic       e_done = 1'b0;
  logic [7:0] e_fail = 8'd0;

  function automatic logic [4:0] phase_code(input int p);
    if (p == P_QUIET) return 5'd0;
    if (p == P_REQ || p == P_WAIT) return 5'd1;
    if (p == P_POLL) return 5'd2;
    return 5'd15;
  endfunction

  always_comb begin
    n_phase = m_phase;
    n_fails = m_fails;
    if (!link_enable) begin
      n_phase = P_IDLE;
    end else if (m_phase == P_IDLE) begin
      n_phase = P_QUIET;
    end else if (m_phase == P_QUIET) begin
      if ((m_age + 1 >= QC) || (m_age >= 1 && RxElecIdle != '1)) n_phase = P_REQ;
    end else if (m_phase == P_REQ) begin
      n_phase = P_WAIT;
    end else if (m_phase == P_WAIT) begin
      if (Detect_status) begin
        n_phase = P_POLL;
      end else if (m_age + 1 >= DT) begin
        n_phase = P_QUIET;
        n_fails = (m_fails < 255) ? m_fails + 1 : 255;
      end
    end
    n_age = (n_phase == m_phase) ? m_age + 1 : 0;
  end

  always @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= P_IDLE;
      m_age   <= 0;
      m_fails <= 0;
      e_sub   <= 5'd15;
      e_ei    <= 1'b1;
      e_req   <= 1'b0;
      e_done  <= 1'b0;
      e_fail  <= 8'd0;
    end else begin
      m_phase <= n_phase;
      m_age   <= n_age;
      m_fails <= n_fails;
      e_sub   <= phase_code(n_phase);
      e_ei    <= (n_phase != P_POLL);
      e_req   <= (n_phase == P_REQ);
      e_done  <= (n_phase == P_POLL) && (m_phase != P_POLL);
      e_fail  <= 8'(n_fails);
    end
  end

  always @(negedge pclk) begin
    if (cmp_en) begin
      check("model_substate", 32'(substate), 32'(e_sub));
      check("model_elecidle", 32'(ElecIdle_req), 32'(e_ei));
      check("model_detect_req", 32'(Detect_req), 32'(e_req));
      check("model_detect_done", 32'(detect_done), 32'(e_done));
      check("model_fail_cnt", 32'(detect_fail_cnt), 32'(e_fail));
    end
  end

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    cmp_en = 1'b1;
    check("rst_substate", 32'(substate), 15);
    check("rst_elecidle", 32'(ElecIdle_req), 1);
    check("rst_detect_req", 32'(Detect_req), 0);
    check("rst_detect_done", 32'(detect_done), 0);
    check("rst_fail_cnt", 32'(detect_fail_cnt), 0);
    reset_n = 1'b1;
    step(1);
    check("idle_hold", 32'(substate), 15);

    // Enable -> Quiet after one cycle, Quiet lasts QC cycles.
    link_enable = 1'b1;
    step(1);
    check("quiet_entry", 32'(substate), 0);
    step(QC - 1);
    check("quiet_last", 32'(substate), 0);
    check("quiet_no_req", 32'(Detect_req), 0);
    step(1);
    check("req_substate", 32'(substate), 1);
    check("req_pulse", 32'(Detect_req), 1);
    step(1);
    check("req_single", 32'(Detect_req), 0);

    // Detect_status 3 cycles after Detect_req.
    step(2);
    Detect_status = 1'b1;
    step(1);
    Detect_status = 1'b0;
    check("poll_substate", 32'(substate), 2);
    check("poll_elecidle", 32'(ElecIdle_req), 0);
    check("poll_done", 32'(detect_done), 1);
    check("poll_fail_cnt", 32'(detect_fail_cnt), 0);
    step(1);
    check("poll_done_single", 32'(detect_done), 0);
    step(3);
    check("poll_stays", 32'(substate), 2);

    // Receiver activity on cycle 5 of Quiet forces early exit.
    link_enable = 1'b0;
    step(1);
    check("link_off_idle", 32'(substate), 15);
    link_enable = 1'b1;
    step(1);
    step(4);
    RxElecIdle = 4'hB;
    step(1);
    check("rx_exit_substate", 32'(substate), 1);
    check("rx_exit_req", 32'(Detect_req), 1);
    RxElecIdle = 4'hF;
    step(1);
    check("rx_exit_req_single", 32'(Detect_req), 0);

    // Status on the same cycle as the detect timeout: success wins.
    step(DT - 1);
    Detect_status = 1'b1;
    step(1);
    Detect_status = 1'b0;
    check("tie_substate", 32'(substate), 2);
    check("tie_done", 32'(detect_done), 1);
    check("tie_fail_cnt", 32'(detect_fail_cnt), 0);

    // Stray Detect_status during Quiet is ignored.
    link_enable = 1'b0;
    step(1);
    link_enable = 1'b1;
    step(3);
    Detect_status = 1'b1;
    step(1);
    Detect_status = 1'b0;
    check("stray_substate", 32'(substate), 0);
    check("stray_done", 32'(detect_done), 0);

    // Receiver activity on the first Quiet cycle is not acted on.
    link_enable = 1'b0;
    step(1);
    RxElecIdle  = 4'hB;
    link_enable = 1'b1;
    step(1);
    step(1);
    check("rx_first_ignored", 32'(substate), 0);
    step(1);
    check("rx_second_exit", 32'(Detect_req), 1);
    RxElecIdle = 4'hF;

    // Repeated detect timeouts saturate the failure count.
    link_enable = 1'b0;
    step(1);
    link_enable = 1'b1;
    step(1);
    for (int i = 1; i <= 300; i++) begin
      step(QC);
      if (i == 1 || i == 300) check("loop_req", 32'(Detect_req), 1);
      step(DT);
      if (i == 1) check("timeout_still_active", 32'(substate), 1);
      step(1);
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300) begin
        check("timeout_back_quiet", 32'(substate), 0);
        check("timeout_fail_cnt", 32'(detect_fail_cnt), (i < 255) ? i : 255);
      end
    end

    // link_enable drop during the detect wait.
    step(QC);
    step(1);
    step(2);
    link_enable = 1'b0;
    step(1);
    check("wait_abort_substate", 32'(substate), 15);
    check("wait_abort_req", 32'(Detect_req), 0);
    check("wait_abort_fail_kept", 32'(detect_fail_cnt), 255);
    step(1);
    check("wait_abort_req_low", 32'(Detect_req), 0);

    // Asynchronous reset in the middle of Quiet.
    link_enable = 1'b1;
    step(1);
    step(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_substate", 32'(substate), 15);
    check("async_rst_elecidle", 32'(ElecIdle_req), 1);
    check("async_rst_req", 32'(Detect_req), 0);
    check("async_rst_done", 32'(detect_done), 0);
    check("async_rst_fail_cnt", 32'(detect_fail_cnt), 0);
    step(2);
    reset_n = 1'b1;
    step(1);
    check("post_rst_quiet", 32'(substate), 0);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
